// File: rtl/tinyml_buf_pkg.sv
// Shared types for the tinyml buffer controller and its read-port arbiters.
package tinyml_buf_pkg;

    localparam int BUF_ID_W       = 5;
    localparam int TILE_ELEMS_DEF = 32;
    localparam int DATA_WIDTH_DEF = 8;

    typedef logic signed [DATA_WIDTH_DEF-1:0] tile_t [TILE_ELEMS_DEF];

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REWIND,
        ARB_ISSUE,
        ARB_DRAIN
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts at ptr and wraps, returning a one-hot winner and its index.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [N-1:0]         win_oh,
    output logic [$clog2(N)-1:0] win_idx
);

    localparam int IW = $clog2(N);

    function automatic logic [IW-1:0] rot(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    assign any = |req;

    // Walk from the farthest offset down so the closest requester to ptr wins last.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[rot(ptr, i)]) begin
                win_oh              = '0;
                win_oh[rot(ptr, i)] = 1'b1;
                win_idx             = rot(ptr, i);
            end
        end
    end

endmodule

// File: rtl/vec_read_arbiter.sv
// Burst-granting arbiter for the shared vector-buffer read port; issues reads and routes returns.
// state  | meaning
// IDLE   | waiting for a request, round-robin pick on any req
// REWIND | one-cycle cache clear before the burst
// ISSUE  | one read enable per cycle until the tile count expires
// DRAIN  | waiting for outstanding returns to come back
module vec_read_arbiter
    import tinyml_buf_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int TILE_ELEMS   = 32,
    parameter int READ_LATENCY = 2,
    parameter int LEN_W        = 10
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [NUM_REQ-1:0][BUF_ID_W-1:0]        req_buf_id,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]           req_len,
    input  logic [NUM_REQ-1:0]                      req_rewind,
    output logic [NUM_REQ-1:0]                      gnt,
    output logic [NUM_REQ-1:0]                      rsp_valid,
    output logic [NUM_REQ-1:0]                      rsp_last,
    output logic [NUM_REQ-1:0]                      rsp_done,
    output logic signed [TILE_ELEMS*DATA_WIDTH-1:0] rsp_tile,
    output logic                                    buf_rd_en,
    output logic [BUF_ID_W-1:0]                     buf_rd_id,
    output logic                                    buf_clr_cache,
    input  logic [TILE_ELEMS*DATA_WIDTH-1:0]        buf_rd_tile,
    input  logic                                    buf_rd_valid,
    output logic                                    busy
);

    localparam int IW   = $clog2(NUM_REQ);
    localparam int IF_W = $clog2(READ_LATENCY + 2);

    arb_state_e           state, state_nxt;
    logic [IW-1:0]        rr_ptr, win_idx;
    logic [NUM_REQ-1:0]   win_oh, owner;
    logic                 any_req;
    logic [BUF_ID_W-1:0]  id_q;
    logic [LEN_W-1:0]     tile_cnt, ret_cnt, sel_len;
    logic [IF_W-1:0]      inflight;
    logic                 zero_len, sel_rew;
    logic                 issue, accept, drain_done;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .any     (any_req),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign sel_len    = req_len[win_idx];
    assign sel_rew    = req_rewind[win_idx];
    assign issue      = (state == ARB_ISSUE);
    // Returns are only owned while some are still expected; stray ones are dropped.
    assign accept     = buf_rd_valid && (ret_cnt != '0);
    assign drain_done = (inflight == '0) || ((inflight == IF_W'(1)) && accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    if (sel_len == '0)  state_nxt = ARB_DRAIN;
                    else if (sel_rew)   state_nxt = ARB_REWIND;
                    else                state_nxt = ARB_ISSUE;
                end
            end
            ARB_REWIND: state_nxt = ARB_ISSUE;
            ARB_ISSUE:  if (tile_cnt == LEN_W'(1)) state_nxt = ARB_DRAIN;
            ARB_DRAIN:  if (drain_done) state_nxt = ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        buf_rd_en     = issue;
        buf_rd_id     = issue ? id_q : '0;
        buf_clr_cache = (state == ARB_REWIND);
        busy          = (state != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            id_q      <= '0;
            tile_cnt  <= '0;
            ret_cnt   <= '0;
            inflight  <= '0;
            zero_len  <= 1'b0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_last  <= '0;
            rsp_done  <= '0;
            rsp_tile  <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_last  <= '0;
            rsp_done  <= '0;
            inflight  <= inflight + IF_W'(issue) - IF_W'(accept);
            if (state == ARB_IDLE && any_req) begin
                gnt      <= win_oh;
                owner    <= win_oh;
                id_q     <= req_buf_id[win_idx];
                tile_cnt <= sel_len;
                ret_cnt  <= sel_len;
                zero_len <= (sel_len == '0);
                if (win_idx == IW'(NUM_REQ - 1)) rr_ptr <= '0;
                else                             rr_ptr <= win_idx + IW'(1);
            end
            if (issue) tile_cnt <= tile_cnt - LEN_W'(1);
            if (accept) begin
                rsp_tile  <= buf_rd_tile;
                rsp_valid <= owner;
                ret_cnt   <= ret_cnt - LEN_W'(1);
                if (ret_cnt == LEN_W'(1)) begin
                    rsp_last <= owner;
                    rsp_done <= owner;
                end
            end
            // Empty bursts complete on their single DRAIN cycle with done alone.
            if (state == ARB_DRAIN && zero_len) begin
                rsp_done <= owner;
                zero_len <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    logic stray_rd_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stray_rd_valid <= 1'b0;
        else     stray_rd_valid <= stray_rd_valid | (buf_rd_valid && (ret_cnt == '0));
    end
`endif

endmodule
